// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timer FSM states and configuration defaults/minimums.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEFAULT_PRESCALE   = 8;
  localparam int MIN_PRESCALE       = 4;
  localparam int DEFAULT_FRAME_BITS = 10;
  localparam int MIN_FRAME_BITS     = 2;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// UART RX bit-timing engine: edge/bit counters with per-frame latched config,
// mid-bit 3-sample strobes, bit/frame done pulses and an end-of-frame hold.
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [2:0]            sample_stb,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  function automatic logic [PRESCALE_W-1:0] san_prescale(input logic [PRESCALE_W-1:0] p);
    return (p < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(DEFAULT_PRESCALE) : p;
  endfunction

  function automatic logic [BIT_CNT_W-1:0] san_frame(input logic [BIT_CNT_W-1:0] f);
    return (f < BIT_CNT_W'(MIN_FRAME_BITS)) ? BIT_CNT_W'(DEFAULT_FRAME_BITS) : f;
  endfunction

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d, p_q, p_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d, f_q, f_d;
  logic                  err_q, err_d;

  logic [PRESCALE_W-1:0] p_san, pe, mid;
  logic [BIT_CNT_W-1:0]  f_san, fe;
  logic                  err_san, last_edge, last_bit, active;

  assign p_san   = san_prescale(prescale);
  assign f_san   = san_frame(frame_bits);
  assign err_san = (prescale < PRESCALE_W'(MIN_PRESCALE)) ||
                   (frame_bits < BIT_CNT_W'(MIN_FRAME_BITS));

  // In IDLE the live (sanitised) inputs drive the decode; once running, the latched copy.
  assign pe  = (state_q == IDLE) ? p_san : p_q;
  assign fe  = (state_q == IDLE) ? f_san : f_q;
  assign mid = pe >> 1;

  assign last_edge = (edge_q == pe - PRESCALE_W'(1));
  assign last_bit  = (bit_q == fe - BIT_CNT_W'(1));

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    f_d     = f_q;
    err_d   = err_q;
    if (!enable) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // This cycle is edge 0 of bit 0, so the next edge is 1.
          state_d = RUN;
          edge_d  = PRESCALE_W'(1);
          bit_d   = '0;
          p_d     = p_san;
          f_d     = f_san;
          err_d   = err_san;
        end
        RUN: begin
          if (last_edge && last_bit) begin
            state_d = HOLD;
            edge_d  = '0;
            bit_d   = '0;
          end else if (last_edge) begin
            edge_d = '0;
            bit_d  = bit_q + BIT_CNT_W'(1);
          end else begin
            edge_d = edge_q + PRESCALE_W'(1);
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= '0;
      f_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      f_q     <= f_d;
      err_q   <= err_d;
    end
  end

  assign active = enable && (state_q != HOLD);

  assign sample_stb[0] = active && (edge_q == mid - PRESCALE_W'(1));
  assign sample_stb[1] = active && (edge_q == mid);
  assign sample_stb[2] = active && (edge_q == mid + PRESCALE_W'(1));
  assign bit_done      = active && last_edge;
  assign frame_done    = bit_done && last_bit;

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench: frame-position model (enabled-cycle index n -> edge n%P, bit n/P)
// compared every cycle, plus directed frames with literal expectations.
module tb_uart_rx_bit_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] frame_bits = 4'd10;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [2:0] sample_stb;
  logic       bit_done, frame_done, cfg_err;

  uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .prescale(prescale), .frame_bits(frame_bits),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sample_stb(sample_stb),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sanp(input int p);
    return (p >= 4) ? p : 8;
  endfunction
  function automatic int sanf(input int f);
    return (f >= 2) ? f : 10;
  endfunction

  // Model: frame position counted as number of enabled cycles since frame start.
  bit m_active, m_hold, m_err;
  int m_n, m_p, m_f;

  always @(posedge CLK or negedge RST) begin
    if (!RST || !enable) begin
      m_active <= 1'b0;
      m_hold   <= 1'b0;
      m_err    <= 1'b0;
      m_n      <= 0;
    end else if (m_hold) begin
      m_hold <= 1'b1;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_p      <= sanp(int'(prescale));
      m_f      <= sanf(int'(frame_bits));
      m_err    <= (prescale < 6'd4) || (frame_bits < 4'd2);
      m_n      <= 1;
    end else if (m_n == m_p * m_f - 1) begin
      m_active <= 1'b0;
      m_hold   <= 1'b1;
      m_n      <= 0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge CLK) begin : compare
    int e, b, pe, fe, mid;
    logic en;
    logic [2:0] stb;
    logic bd, fd, ce;
    if (m_active) begin
      e = m_n % m_p; b = m_n / m_p; pe = m_p; fe = m_f;
    end else if (m_hold) begin
      e = 0; b = 0; pe = m_p; fe = m_f;
    end else begin
      e = 0; b = 0; pe = sanp(int'(prescale)); fe = sanf(int'(frame_bits));
    end
    en  = enable && !m_hold;
    mid = pe / 2;
    for (int k = 0; k < 3; k++) stb[k] = en && (e == mid - 1 + k);
    bd = en && (e == pe - 1);
    fd = bd && (b == fe - 1);
    ce = (m_active || m_hold) ? m_err : 1'b0;
    chk("edge_cnt", 32'(edge_cnt), 32'(e));
    chk("bit_cnt", 32'(bit_cnt), 32'(b));
    chk("sample_stb", 32'(sample_stb), 32'(stb));
    chk("bit_done", 32'(bit_done), 32'(bd));
    chk("frame_done", 32'(frame_done), 32'(fd));
    chk("cfg_err", 32'(cfg_err), 32'(ce));
  end

  task automatic go_idle();
    enable = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Starts a frame from IDLE; cycle 0 is the first enabled (IDLE) cycle.
  task automatic run_frame(input int p, input int f, input int ncyc, input int chg_at,
                           input int chg_p, output int fd_at, output int fd_bit,
                           output int stb0_e);
    prescale = 6'(p); frame_bits = 4'(f); enable = 1'b1;
    fd_at = -1; fd_bit = -1; stb0_e = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == chg_at) prescale = 6'(chg_p);
      @(negedge CLK);
      if (frame_done && fd_at < 0) begin fd_at = c; fd_bit = int'(bit_cnt); end
      if (sample_stb[0] && stb0_e < 0) stb0_e = int'(edge_cnt);
      @(posedge CLK); #1;
    end
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int sweep_p[5]  = '{4, 5, 16, 31, 63};
  int sweep_s0[5] = '{1, 1, 7, 14, 30};
  int sweep_fd[5] = '{43, 54, 175, 340, 692};

  initial begin : stim
    int fd_at, fd_bit, s0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rst_edge", 32'(edge_cnt), 0);
    chk("rst_bit", 32'(bit_cnt), 0);
    chk("rst_cfg", 32'(cfg_err), 0);
    chk("rst_stb", 32'({sample_stb, bit_done, frame_done}), 0);
    @(posedge CLK); #1;

    // P=8, F=10, then a few HOLD cycles with enable still high
    run_frame(8, 10, 86, -1, 0, fd_at, fd_bit, s0);
    chk("p8_fd_cycle", 32'(fd_at), 79);
    chk("p8_fd_bit", 32'(fd_bit), 9);
    chk("p8_stb0_edge", 32'(s0), 3);
    chk("p8_hold_edge", 32'(edge_cnt), 0);
    go_idle();

    foreach (sweep_p[i]) begin
      run_frame(sweep_p[i], 11, sweep_p[i] * 11 + 3, -1, 0, fd_at, fd_bit, s0);
      chk("sweep_fd_cycle", 32'(fd_at), 32'(sweep_fd[i]));
      chk("sweep_stb0_edge", 32'(s0), 32'(sweep_s0[i]));
      go_idle();
    end

    // Illegal config falls back to 8/10 and flags cfg_err
    run_frame(2, 1, 84, -1, 0, fd_at, fd_bit, s0);
    chk("bad_fd_cycle", 32'(fd_at), 79);
    chk("bad_stb0_edge", 32'(s0), 3);
    @(negedge CLK);
    chk("bad_cfg_hold", 32'(cfg_err), 1);
    @(posedge CLK); #1;
    enable = 1'b0;
    @(negedge CLK);
    chk("bad_cfg_before_clear", 32'(cfg_err), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bad_cfg_cleared", 32'(cfg_err), 0);
    @(posedge CLK); #1;

    // Prescale change mid-frame is ignored until the next frame
    run_frame(8, 10, 84, 26, 16, fd_at, fd_bit, s0);
    chk("chg_fd_cycle", 32'(fd_at), 79);
    go_idle();
    run_frame(16, 10, 164, -1, 0, fd_at, fd_bit, s0);
    chk("p16_fd_cycle", 32'(fd_at), 159);
    chk("p16_stb0_edge", 32'(s0), 7);
    go_idle();

    // Drop enable while at edge 5 of bit 4
    run_frame(8, 10, 37, -1, 0, fd_at, fd_bit, s0);
    chk("drop_no_fd", 32'(fd_at), 32'(-1));
    enable = 1'b0;
    @(negedge CLK);
    chk("drop_edge_before", 32'(edge_cnt), 5);
    chk("drop_bit_before", 32'(bit_cnt), 4);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("drop_edge_after", 32'(edge_cnt), 0);
    chk("drop_bit_after", 32'(bit_cnt), 0);
    @(posedge CLK); #1;
    run_frame(8, 10, 82, -1, 0, fd_at, fd_bit, s0);
    chk("refresh_fd_cycle", 32'(fd_at), 79);
    go_idle();

    // Async reset during bit 6
    run_frame(8, 10, 50, -1, 0, fd_at, fd_bit, s0);
    #3 RST = 1'b0;
    #1;
    chk("arst_edge", 32'(edge_cnt), 0);
    chk("arst_bit", 32'(bit_cnt), 0);
    chk("arst_outs", 32'({sample_stb, bit_done, frame_done, cfg_err}), 0);
    @(posedge CLK); #1 RST = 1'b1;
    run_frame(8, 10, 82, -1, 0, fd_at, fd_bit, s0);
    chk("arst_fd_cycle", 32'(fd_at), 79);
    go_idle();

    // Random traffic: config churn, enable toggles, occasional async reset
    for (int c = 0; c < 4000; c++) begin
      if (enable) begin
        if ($urandom_range(0, 79) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 29) == 0)
        prescale = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 10));
      if ($urandom_range(0, 29) == 0) frame_bits = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        #3 RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
      end else begin
        @(posedge CLK); #1;
      end
    end

    enable = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
